// File: rtl/ls_dma_engine.sv
// rtl/ls_dma_engine.sv - Local-store DMA engine moving quadwords between LS and an external bus.
module ls_dma_engine #(
  parameter int LS_AW   = 11,
  parameter int LEN_W   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [LS_AW-1:0] cmd_lsa,
  input  logic [31:0]      cmd_ea,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [4:0]       cmd_tag,
  output logic             ls_req,
  output logic             ls_we,
  output logic [LS_AW-1:0] ls_addr,
  output logic [127:0]     ls_wdata,
  input  logic             ls_gnt,
  input  logic [127:0]     ls_rdata,
  output logic             ext_req_valid,
  input  logic             ext_req_ready,
  output logic             ext_req_we,
  output logic [31:0]      ext_req_addr,
  output logic [127:0]     ext_wdata,
  input  logic             ext_rsp_valid,
  output logic             ext_rsp_ready,
  input  logic [127:0]     ext_rdata,
  output logic             done,
  output logic [4:0]       done_tag
);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_GET, S_PUT, S_DONE} state_t;
  state_t state, state_nx;

  logic [LS_AW-1:0] lsa;
  logic [31:0]      ea;
  logic [LEN_W-1:0] len;
  logic [4:0]       tag;
  // cnt_a: reads issued (ext reads in GET, LS reads in PUT); cnt_b: quadwords retired
  logic [LEN_W-1:0] cnt_a, cnt_b;
  logic [OW-1:0]    outstanding;
  logic [127:0]     fifo [2];
  logic             wptr, rptr, inflight;
  logic [1:0]       fifo_count;
  logic             req_hs, rsp_hs, ls_hs;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    cmd_ready     = 1'b0;
    ls_req        = 1'b0;
    ls_we         = 1'b0;
    ls_addr       = '0;
    ls_wdata      = '0;
    ext_req_valid = 1'b0;
    ext_req_we    = 1'b0;
    ext_req_addr  = '0;
    ext_wdata     = '0;
    ext_rsp_ready = 1'b0;
    done          = 1'b0;
    done_tag      = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0) state_nx = S_DONE;
          else               state_nx = cmd_dir ? S_PUT : S_GET;
        end
      end
      S_GET: begin
        ext_req_valid = (cnt_a < len) && (outstanding < OW'(MAX_OUT));
        ext_req_addr  = ea + 32'(cnt_a);
        ext_rsp_ready = ls_gnt;
        ls_req        = ext_rsp_valid;
        ls_we         = ext_rsp_valid;
        ls_addr       = lsa + LS_AW'(cnt_b);
        ls_wdata      = ext_rdata;
        if (cnt_b == len) state_nx = S_DONE;
      end
      S_PUT: begin
        // A read granted last cycle already owns a FIFO slot
        ls_req        = (cnt_a < len) && ((fifo_count + 2'(inflight)) < 2'd2);
        ls_addr       = lsa + LS_AW'(cnt_a);
        ext_req_valid = (fifo_count != 2'd0);
        ext_req_we    = 1'b1;
        ext_req_addr  = ea + 32'(cnt_b);
        ext_wdata     = fifo[rptr];
        if (cnt_b == len) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        done_tag = tag;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign req_hs = ext_req_valid & ext_req_ready;
  assign rsp_hs = ext_rsp_valid & ext_rsp_ready;
  assign ls_hs  = ls_req & ls_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      lsa         <= '0;
      ea          <= '0;
      len         <= '0;
      tag         <= '0;
      cnt_a       <= '0;
      cnt_b       <= '0;
      outstanding <= '0;
      fifo[0]     <= '0;
      fifo[1]     <= '0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      inflight    <= 1'b0;
      fifo_count  <= '0;
    end else begin
      if (state == S_IDLE && cmd_valid) begin
        lsa         <= cmd_lsa;
        ea          <= cmd_ea;
        len         <= cmd_len;
        tag         <= cmd_tag;
        cnt_a       <= '0;
        cnt_b       <= '0;
        outstanding <= '0;
        wptr        <= 1'b0;
        rptr        <= 1'b0;
        inflight    <= 1'b0;
        fifo_count  <= '0;
      end
      if (state == S_GET) begin
        if (req_hs) cnt_a <= cnt_a + LEN_W'(1);
        if (rsp_hs) cnt_b <= cnt_b + LEN_W'(1);
        case ({req_hs, rsp_hs})
          2'b10:   outstanding <= outstanding + OW'(1);
          2'b01:   outstanding <= outstanding - OW'(1);
          default: outstanding <= outstanding;
        endcase
      end
      if (state == S_PUT) begin
        inflight <= ls_hs;
        if (ls_hs) cnt_a <= cnt_a + LEN_W'(1);
        if (inflight) begin
          fifo[wptr] <= ls_rdata;
          wptr       <= ~wptr;
        end
        if (req_hs) begin
          rptr  <= ~rptr;
          cnt_b <= cnt_b + LEN_W'(1);
        end
        fifo_count <= fifo_count + 2'(inflight) - 2'(req_hs);
      end
    end
  end
endmodule

// File: tb/tb_ls_dma_engine.sv
// tb/tb_ls_dma_engine.sv - Self-checking bench for ls_dma_engine with LS and external memory models.
module tb_ls_dma_engine;
  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready, cmd_dir;
  logic [10:0]  cmd_lsa;
  logic [31:0]  cmd_ea;
  logic [7:0]   cmd_len;
  logic [4:0]   cmd_tag;
  logic         ls_req, ls_we, ls_gnt;
  logic [10:0]  ls_addr;
  logic [127:0] ls_wdata, ls_rdata;
  logic         ext_req_valid, ext_req_ready, ext_req_we;
  logic [31:0]  ext_req_addr;
  logic [127:0] ext_wdata, ext_rdata;
  logic         ext_rsp_valid, ext_rsp_ready;
  logic         done;
  logic [4:0]   done_tag;

  ls_dma_engine dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_lsa(cmd_lsa),
    .cmd_ea(cmd_ea), .cmd_len(cmd_len), .cmd_tag(cmd_tag),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rdata(ls_rdata),
    .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready), .ext_req_we(ext_req_we),
    .ext_req_addr(ext_req_addr), .ext_wdata(ext_wdata),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rdata(ext_rdata),
    .done(done), .done_tag(done_tag)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [127:0] data; } ext_t;
  typedef struct { logic [10:0] addr; logic we; logic [127:0] data; } ls_t;
  typedef struct { logic [31:0] addr; int avail; } rsp_t;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  logic [127:0] ls_mem [2048];
  ls_t  exp_ls[$];
  ext_t exp_ext[$];
  rsp_t rspq[$];
  ext_t ext_log[$];
  logic [10:0] ls_wr_log[$], ls_rd_log[$];
  bit   active = 0, cur_dir = 0, accepted = 0, pend_v = 0;
  logic [4:0] cur_tag = '0, last_tag = '0;
  logic [10:0] pend_addr = '0;
  int   acc_cyc = 0, done_cyc = 0, done_count = 0, outst = 0, max_out = 0, stall_seen = 0;
  int   rsp_delay = 0, rdy_lo_from = -1, rdy_lo_to = -1;
  bit   gnt_toggle = 0;
  bit   p_ls_stall = 0, p_ext_stall = 0, p_ls_we = 0, p_ext_we = 0;
  logic [10:0]  p_ls_addr;
  logic [31:0]  p_ext_addr;
  logic [127:0] p_ls_wdata, p_ext_wdata;

  function automatic logic [127:0] ext_pat(input logic [31:0] a);
    return {4{a ^ 32'h5A5A0000}};
  endfunction
  function automatic logic [127:0] ls_pat(input int i);
    logic [15:0] lo;
    lo = 16'(i);
    return {4{16'hC0DE, lo}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input bit bad, input string what);
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    end
  endtask

  // Environment driver and per-cycle compare process
  initial begin
    for (int i = 0; i < 2048; i++) ls_mem[i] = ls_pat(i);
    forever begin
      @(negedge clk);
      cyc++;
      #1;
      ls_gnt        = reset ? 1'b0 : (gnt_toggle ? cyc[0] : 1'b1);
      ext_req_ready = (reset || (cyc >= rdy_lo_from && cyc < rdy_lo_to)) ? 1'b0 : 1'b1;
      ls_rdata      = pend_v ? ls_mem[pend_addr] : {4{32'hBADC0FFE}};
      pend_v        = 0;
      if (rspq.size() > 0 && rspq[0].avail <= cyc) begin
        ext_rsp_valid = 1'b1;
        ext_rdata     = ext_pat(rspq[0].addr);
      end else begin
        ext_rsp_valid = 1'b0;
        ext_rdata     = {4{32'hDEADBEEF}};
      end
      #1;
      if (reset) begin
        active = 0;
        exp_ls.delete();
        exp_ext.delete();
        p_ls_stall  = 0;
        p_ext_stall = 0;
      end else begin
        if (!active) begin
          chk("idle_cmd_ready", cmd_ready, 1'b1);
          chk("idle_ls_req", ls_req, 1'b0);
          chk("idle_ext_req_valid", ext_req_valid, 1'b0);
          chk("idle_ext_rsp_ready", ext_rsp_ready, 1'b0);
          chk("idle_done", done, 1'b0);
        end else begin
          chk("busy_cmd_ready", cmd_ready, 1'b0);
        end
        if (p_ls_stall) begin
          chk("ls_hold_req", ls_req, 1'b1);
          chk("ls_hold_addr", ls_addr, p_ls_addr);
          chk("ls_hold_we", ls_we, p_ls_we);
          if (p_ls_we) chk("ls_hold_wdata", ls_wdata, p_ls_wdata);
        end
        if (p_ext_stall) begin
          chk("ext_hold_valid", ext_req_valid, 1'b1);
          chk("ext_hold_addr", ext_req_addr, p_ext_addr);
          chk("ext_hold_we", ext_req_we, p_ext_we);
          if (p_ext_we) chk("ext_hold_wdata", ext_wdata, p_ext_wdata);
        end
        p_ls_stall  = ls_req && !ls_gnt;
        p_ls_addr   = ls_addr;
        p_ls_we     = ls_we;
        p_ls_wdata  = ls_wdata;
        p_ext_stall = ext_req_valid && !ext_req_ready;
        p_ext_addr  = ext_req_addr;
        p_ext_we    = ext_req_we;
        p_ext_wdata = ext_wdata;
        if (p_ext_stall) stall_seen++;
        if (active && !cur_dir && ext_rsp_valid) begin
          chk("get_ls_req", ls_req, 1'b1);
          chk("get_ls_we", ls_we, 1'b1);
          chk("get_ls_wdata", ls_wdata, ext_rdata);
          chk("get_rsp_ready", ext_rsp_ready, ls_gnt);
        end
        if (ls_req && ls_gnt) begin
          if (exp_ls.size() == 0) flag("ls_extra", 1'b1, "unexpected LS access");
          else begin
            ls_t e;
            e = exp_ls.pop_front();
            chk("ls_addr", ls_addr, e.addr);
            chk("ls_we", ls_we, e.we);
            if (e.we) chk("ls_wdata", ls_wdata, e.data);
          end
          if (ls_we) begin
            ls_mem[ls_addr] = ls_wdata;
            ls_wr_log.push_back(ls_addr);
          end else begin
            pend_v    = 1;
            pend_addr = ls_addr;
            ls_rd_log.push_back(ls_addr);
          end
        end
        if (ext_req_valid && ext_req_ready) begin
          if (exp_ext.size() == 0) flag("ext_extra", 1'b1, "unexpected external request");
          else begin
            ext_t e;
            e = exp_ext.pop_front();
            chk("ext_addr", ext_req_addr, e.addr);
            chk("ext_we", ext_req_we, e.we);
            if (e.we) chk("ext_wdata", ext_wdata, e.data);
          end
          ext_log.push_back('{ext_req_addr, ext_req_we, ext_wdata});
          if (!ext_req_we) begin
            rspq.push_back('{ext_req_addr, cyc + 1 + rsp_delay});
            outst++;
          end
        end
        if (ext_rsp_valid && ext_rsp_ready) begin
          rsp_t r;
          r = rspq.pop_front();
          outst--;
        end
        if (outst > max_out) max_out = outst;
        if (active && !cur_dir) flag("outstanding_limit", outst > 4, "more than 4 reads outstanding");
        if (done) begin
          chk("done_active", active, 1'b1);
          chk("done_tag", done_tag, cur_tag);
          chk("done_ls_left", exp_ls.size(), 0);
          chk("done_ext_left", exp_ext.size(), 0);
          active     = 0;
          done_count++;
          done_cyc   = cyc;
          last_tag   = done_tag;
        end
        if (cmd_valid && cmd_ready) begin
          active   = 1;
          accepted = 1;
          cur_dir  = cmd_dir;
          cur_tag  = cmd_tag;
          acc_cyc  = cyc;
          for (int i = 0; i < int'(cmd_len); i++) begin
            logic [10:0] a;
            logic [31:0] x;
            a = cmd_lsa + 11'(i);
            x = cmd_ea + 32'(i);
            exp_ls.push_back('{a, !cmd_dir, cmd_dir ? 128'h0 : ext_pat(x)});
            exp_ext.push_back('{x, cmd_dir, cmd_dir ? ls_mem[a] : 128'h0});
          end
        end
      end
    end
  end

  task automatic run_cmd(input logic dir, input logic [10:0] lsa, input logic [31:0] ea,
                         input logic [7:0] len, input logic [4:0] tag);
    int t;
    t = 0;
    @(negedge clk);
    accepted  = 0;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_lsa   = lsa;
    cmd_ea    = ea;
    cmd_len   = len;
    cmd_tag   = tag;
    do begin
      @(negedge clk);
      t++;
    end while (!accepted && t < 20);
    cmd_valid = 1'b0;
    flag("cmd_accept", !accepted, "command not accepted within 20 cycles");
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_count < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("done_count", done_count, target);
  endtask

  task automatic clear_logs();
    ext_log.delete();
    ls_wr_log.delete();
    ls_rd_log.delete();
    max_out    = 0;
    stall_seen = 0;
  endtask

  initial begin
    int t;
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_lsa = '0; cmd_ea = '0;
    cmd_len = '0; cmd_tag = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_ls_req", ls_req, 1'b0);
    chk("rst_ext_req_valid", ext_req_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_done_tag", done_tag, 5'd0);
    chk("rst_ls_addr", ls_addr, 11'd0);

    clear_logs();
    run_cmd(1'b0, 11'd5, 32'h100, 8'd3, 5'd1);
    wait_done(1);
    chk("get1_wr0", ls_wr_log[0], 11'd5);
    chk("get1_wr2", ls_wr_log[2], 11'd7);
    chk("get1_ext0", ext_log[0].addr, 32'h100);
    chk("get1_ext2", ext_log[2].addr, 32'h102);
    chk("get1_ls5", ls_mem[5], {4{32'h5A5A0100}});
    chk("get1_ls7", ls_mem[7], {4{32'h5A5A0102}});
    chk("get1_tag", last_tag, 5'd1);

    clear_logs();
    run_cmd(1'b1, 11'd2046, 32'h4000, 8'd4, 5'd2);
    wait_done(2);
    chk("put_rd0", ls_rd_log[0], 11'd2046);
    chk("put_rd2", ls_rd_log[2], 11'd0);
    chk("put_rd3", ls_rd_log[3], 11'd1);
    chk("put_ext3_addr", ext_log[3].addr, 32'h4003);
    chk("put_ext1_data", ext_log[1].data, {4{32'hC0DE07FF}});
    chk("put_ext2_data", ext_log[2].data, {4{32'hC0DE0000}});

    clear_logs();
    rsp_delay = 10;
    run_cmd(1'b0, 11'd300, 32'h800, 8'd8, 5'd3);
    wait_done(3);
    rsp_delay = 0;
    chk("get8_max_out", max_out, 4);
    chk("get8_writes", ls_wr_log.size(), 8);

    clear_logs();
    gnt_toggle  = 1;
    rdy_lo_from = cyc + 5;
    rdy_lo_to   = cyc + 8;
    run_cmd(1'b1, 11'd10, 32'h1000, 8'd6, 5'd4);
    wait_done(4);
    gnt_toggle = 0;
    chk("put6_sent", ext_log.size(), 6);
    chk("put6_ext5_data", ext_log[5].data, {4{32'hC0DE000F}});
    flag("put6_stalled", stall_seen == 0, "no ext_req_ready stall was exercised");

    clear_logs();
    run_cmd(1'b0, 11'd0, 32'h0, 8'd0, 5'd9);
    wait_done(5);
    chk("len0_latency", done_cyc - acc_cyc, 1);
    chk("len0_tag", last_tag, 5'd9);
    chk("len0_no_ls", ls_wr_log.size() + ls_rd_log.size(), 0);
    chk("len0_no_ext", ext_log.size(), 0);

    clear_logs();
    run_cmd(1'b0, 11'd100, 32'h200, 8'd6, 5'd5);
    t = 0;
    while (ls_wr_log.size() < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    flag("midget_progress", ls_wr_log.size() < 2, "two writes never happened");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #3;
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_ls_req", ls_req, 1'b0);
    chk("mid_rst_ext_req_valid", ext_req_valid, 1'b0);
    chk("mid_rst_rsp_ready", ext_rsp_ready, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", done_count, 5);
    rspq.delete();
    outst = 0;
    clear_logs();
    run_cmd(1'b0, 11'd50, 32'h300, 8'd2, 5'd7);
    wait_done(6);
    chk("post_rst_tag", last_tag, 5'd7);
    chk("post_rst_ls51", ls_mem[51], {4{32'h5A5A0301}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
